id_ex_reg: RTL and testbench

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_if.sv | 44 ++++
 rtl/id_ex_reg.sv | 107 ++++++++++
 tb/tb_id_ex_reg.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_if.sv
// ID/EX pipeline-register bundle: decoded ID-stage fields in, registered EX-stage fields out,
// plus the hazard/stall side-band shared with the front end.
interface id_ex_if;
    logic        ID_shift_imm, ID_m_size, ID_m_enable, ID_m_rw;
    logic        ID_Load_Inst, ID_S, ID_RF_enable, ID_B_instr;
    logic [3:0]  ID_ALU_Op;
    logic [31:0] ID_A, ID_B;
    logic [11:0] ID_imm;
    logic [3:0]  ID_Rn, ID_Rm, ID_Rd;
    logic        ID_use_Rn, ID_use_Rm;
    logic        cond_pass, flush, hold;

    logic        EX_shift_imm, EX_m_size, EX_m_enable, EX_m_rw;
    logic        EX_Load_Inst, EX_S, EX_RF_enable, EX_B_instr;
    logic [3:0]  EX_ALU_Op;
    logic [31:0] EX_A, EX_B;
    logic [11:0] EX_imm;
    logic [3:0]  EX_Rn, EX_Rm, EX_Rd;
    logic        EX_valid;
    logic        stall_IF_ID;
    logic [15:0] bubble_cnt;

    modport master (
        output ID_shift_imm, ID_m_size, ID_m_enable, ID_m_rw,
        output ID_Load_Inst, ID_S, ID_RF_enable, ID_B_instr,
        output ID_ALU_Op, ID_A, ID_B, ID_imm, ID_Rn, ID_Rm, ID_Rd,
        output ID_use_Rn, ID_use_Rm, cond_pass, flush, hold,
        input  EX_shift_imm, EX_m_size, EX_m_enable, EX_m_rw,
        input  EX_Load_Inst, EX_S, EX_RF_enable, EX_B_instr,
        input  EX_ALU_Op, EX_A, EX_B, EX_imm, EX_Rn, EX_Rm, EX_Rd,
        input  EX_valid, stall_IF_ID, bubble_cnt
    );

    modport slave (
        input  ID_shift_imm, ID_m_size, ID_m_enable, ID_m_rw,
        input  ID_Load_Inst, ID_S, ID_RF_enable, ID_B_instr,
        input  ID_ALU_Op, ID_A, ID_B, ID_imm, ID_Rn, ID_Rm, ID_Rd,
        input  ID_use_Rn, ID_use_Rm, cond_pass, flush, hold,
        output EX_shift_imm, EX_m_size, EX_m_enable, EX_m_rw,
        output EX_Load_Inst, EX_S, EX_RF_enable, EX_B_instr,
        output EX_ALU_Op, EX_A, EX_B, EX_imm, EX_Rn, EX_Rm, EX_Rd,
        output EX_valid, stall_IF_ID, bubble_cnt
    );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// flush / hazard / failed condition, memory-stall hold and a saturating bubble counter.
module id_ex_reg (
    input  logic     clk,
    input  logic     reset_n,
    id_ex_if.slave   bus
);
    // Control bit order: {shift_imm, m_size, m_enable, m_rw, load, S, rf_enable, b_instr}
    logic [7:0]  ctrl_d, ctrl_q;
    logic [3:0]  alu_op_d, alu_op_q;
    logic [31:0] a_d, a_q, b_d, b_q;
    logic [11:0] imm_d, imm_q;
    logic [3:0]  rn_d, rn_q, rm_d, rm_q, rd_d, rd_q;
    logic        valid_d, valid_q;
    logic [15:0] cnt_d, cnt_q;
    logic        hz_s, bubble_s;

    assign hz_s = valid_q & ctrl_q[3] &
                  ((bus.ID_use_Rn & (bus.ID_Rn == rd_q)) |
                   (bus.ID_use_Rm & (bus.ID_Rm == rd_q)));
    assign bubble_s        = bus.flush | hz_s | ~bus.cond_pass;
    assign bus.stall_IF_ID = hz_s | bus.hold;

    // Next-state selection: hold freezes, bubble zeroes control but keeps data, else load.
    always_comb begin
        ctrl_d   = ctrl_q;
        alu_op_d = alu_op_q;
        a_d      = a_q;
        b_d      = b_q;
        imm_d    = imm_q;
        rn_d     = rn_q;
        rm_d     = rm_q;
        rd_d     = rd_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        if (bus.hold) begin
            valid_d = valid_q;
        end else begin
            a_d   = bus.ID_A;
            b_d   = bus.ID_B;
            imm_d = bus.ID_imm;
            rn_d  = bus.ID_Rn;
            rm_d  = bus.ID_Rm;
            rd_d  = bus.ID_Rd;
            if (bubble_s) begin
                ctrl_d   = 8'h00;
                alu_op_d = 4'h0;
                valid_d  = 1'b0;
                if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end else begin
                ctrl_d   = {bus.ID_shift_imm, bus.ID_m_size, bus.ID_m_enable, bus.ID_m_rw,
                            bus.ID_Load_Inst, bus.ID_S, bus.ID_RF_enable, bus.ID_B_instr};
                alu_op_d = bus.ID_ALU_Op;
                valid_d  = 1'b1;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q   <= 8'h00;
            alu_op_q <= 4'h0;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            imm_q    <= 12'h0;
            rn_q     <= 4'h0;
            rm_q     <= 4'h0;
            rd_q     <= 4'h0;
            valid_q  <= 1'b0;
            cnt_q    <= 16'h0;
        end else begin
            ctrl_q   <= ctrl_d;
            alu_op_q <= alu_op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            imm_q    <= imm_d;
            rn_q     <= rn_d;
            rm_q     <= rm_d;
            rd_q     <= rd_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.EX_shift_imm = ctrl_q[7];
    assign bus.EX_m_size    = ctrl_q[6];
    assign bus.EX_m_enable  = ctrl_q[5];
    assign bus.EX_m_rw      = ctrl_q[4];
    assign bus.EX_Load_Inst = ctrl_q[3];
    assign bus.EX_S         = ctrl_q[2];
    assign bus.EX_RF_enable = ctrl_q[1];
    assign bus.EX_B_instr   = ctrl_q[0];
    assign bus.EX_ALU_Op    = alu_op_q;
    assign bus.EX_A         = a_q;
    assign bus.EX_B         = b_q;
    assign bus.EX_imm       = imm_q;
    assign bus.EX_Rn        = rn_q;
    assign bus.EX_Rm        = rm_q;
    assign bus.EX_Rd        = rd_q;
    assign bus.EX_valid     = valid_q;
    assign bus.bubble_cnt   = cnt_q;
endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios plus randomized traffic
// compared against a field-level model of the pipeline register.
module tb_id_ex_reg;
    logic clk;
    logic reset_n;
    id_ex_if bus ();

    id_ex_reg dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        shift_imm, m_size, m_enable, m_rw, load_inst, s, rf_enable, b_instr;
        logic [3:0]  alu_op;
        logic [31:0] a, b;
        logic [11:0] imm;
        logic [3:0]  rn, rm, rd;
        logic        valid;
        logic [15:0] cnt;
    } ex_t;

    typedef enum {ACT_HOLD, ACT_BUBBLE, ACT_LOAD} act_e;

    ex_t m;          // reference model of the EX-side state
    int  n_vec = 0;
    int  n_err = 0;

    function automatic ex_t dut_state();
        ex_t r;
        r.shift_imm = bus.EX_shift_imm; r.m_size = bus.EX_m_size;
        r.m_enable  = bus.EX_m_enable;  r.m_rw   = bus.EX_m_rw;
        r.load_inst = bus.EX_Load_Inst; r.s      = bus.EX_S;
        r.rf_enable = bus.EX_RF_enable; r.b_instr = bus.EX_B_instr;
        r.alu_op = bus.EX_ALU_Op; r.a = bus.EX_A; r.b = bus.EX_B; r.imm = bus.EX_imm;
        r.rn = bus.EX_Rn; r.rm = bus.EX_Rm; r.rd = bus.EX_Rd;
        r.valid = bus.EX_valid; r.cnt = bus.bubble_cnt;
        return r;
    endfunction

    function automatic bit model_hazard();
        bit src_hit;
        src_hit = (bus.ID_use_Rn && bus.ID_Rn == m.rd) || (bus.ID_use_Rm && bus.ID_Rm == m.rd);
        return m.valid && m.load_inst && src_hit;
    endfunction

    function automatic bit model_stall();
        return model_hazard() || bus.hold;
    endfunction

    function automatic void model_edge();
        act_e act;
        if (bus.hold)                                          act = ACT_HOLD;
        else if (bus.flush || model_hazard() || !bus.cond_pass) act = ACT_BUBBLE;
        else                                                   act = ACT_LOAD;
        if (act != ACT_HOLD) begin
            m.a = bus.ID_A; m.b = bus.ID_B; m.imm = bus.ID_imm;
            m.rn = bus.ID_Rn; m.rm = bus.ID_Rm; m.rd = bus.ID_Rd;
        end
        if (act == ACT_LOAD) begin
            m.shift_imm = bus.ID_shift_imm; m.m_size = bus.ID_m_size;
            m.m_enable = bus.ID_m_enable; m.m_rw = bus.ID_m_rw;
            m.load_inst = bus.ID_Load_Inst; m.s = bus.ID_S;
            m.rf_enable = bus.ID_RF_enable; m.b_instr = bus.ID_B_instr;
            m.alu_op = bus.ID_ALU_Op; m.valid = 1'b1;
        end else if (act == ACT_BUBBLE) begin
            m.shift_imm = 1'b0; m.m_size = 1'b0; m.m_enable = 1'b0; m.m_rw = 1'b0;
            m.load_inst = 1'b0; m.s = 1'b0; m.rf_enable = 1'b0; m.b_instr = 1'b0;
            m.alu_op = 4'd0; m.valid = 1'b0;
            m.cnt = (int'(m.cnt) + 1 > 65535) ? 16'hFFFF : 16'(int'(m.cnt) + 1);
        end
    endfunction

    task automatic clock_edge();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic rand_id();
        bus.ID_shift_imm = 1'($urandom); bus.ID_m_size = 1'($urandom);
        bus.ID_m_enable = 1'($urandom);  bus.ID_m_rw = 1'($urandom);
        bus.ID_Load_Inst = 1'($urandom); bus.ID_S = 1'($urandom);
        bus.ID_RF_enable = 1'($urandom); bus.ID_B_instr = 1'($urandom);
        bus.ID_ALU_Op = 4'($urandom);
        bus.ID_A = $urandom; bus.ID_B = $urandom; bus.ID_imm = 12'($urandom);
        bus.ID_Rn = 4'($urandom_range(0, 3)); bus.ID_Rm = 4'($urandom_range(0, 3));
        bus.ID_Rd = 4'($urandom_range(0, 3));
        bus.ID_use_Rn = 1'($urandom); bus.ID_use_Rm = 1'($urandom);
    endtask

    task automatic plain_ctrl();
        bus.hold = 1'b0; bus.flush = 1'b0; bus.cond_pass = 1'b1;
    endtask

    task automatic test_reset();
        ex_t got;
        reset_n = 1'b0;
        rand_id(); plain_ctrl();
        repeat (2) @(negedge clk);
        m = '0;
        got = dut_state();
        n_vec++;
        if (got !== m) begin
            n_err++; $display("FAIL reset_state got=%h exp=%h", got, m);
        end
        n_vec++;
        if (bus.stall_IF_ID !== 1'b0) begin
            n_err++; $display("FAIL reset_stall got=%b exp=0", bus.stall_IF_ID);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        rand_id(); plain_ctrl();
        bus.ID_ALU_Op = 4'b0100; bus.ID_RF_enable = 1'b1; bus.ID_Load_Inst = 1'b0;
        clock_edge();
        n_vec++;
        if ({bus.EX_ALU_Op, bus.EX_RF_enable, bus.EX_valid, bus.bubble_cnt} !== {4'b0100, 1'b1, 1'b1, 16'd0}) begin
            n_err++;
            $display("FAIL basic_load got alu=%h rf=%b v=%b cnt=%0d exp alu=4 rf=1 v=1 cnt=0",
                     bus.EX_ALU_Op, bus.EX_RF_enable, bus.EX_valid, bus.bubble_cnt);
        end
        n_vec++;
        if (dut_state() !== m) begin
            n_err++; $display("FAIL basic_fields got=%h exp=%h", dut_state(), m);
        end
    endtask

    task automatic test_load_use();
        logic [15:0] c0;
        rand_id(); plain_ctrl();
        bus.ID_Load_Inst = 1'b1; bus.ID_Rd = 4'd3;
        clock_edge();
        rand_id(); bus.ID_Rn = 4'd3; bus.ID_use_Rn = 1'b1;
        c0 = m.cnt;
        #1;
        n_vec++;
        if (bus.stall_IF_ID !== 1'b1) begin
            n_err++; $display("FAIL loaduse_stall got=%b exp=1", bus.stall_IF_ID);
        end
        clock_edge();
        n_vec++;
        if ({bus.EX_valid, bus.bubble_cnt} !== {1'b0, c0 + 16'd1}) begin
            n_err++; $display("FAIL loaduse_bubble got v=%b cnt=%0d exp v=0 cnt=%0d",
                              bus.EX_valid, bus.bubble_cnt, c0 + 16'd1);
        end
        n_vec++;
        if (bus.stall_IF_ID !== 1'b0) begin
            n_err++; $display("FAIL loaduse_release_stall got=%b exp=0", bus.stall_IF_ID);
        end
        clock_edge();
        n_vec++;
        if (bus.EX_valid !== 1'b1 || dut_state() !== m) begin
            n_err++; $display("FAIL loaduse_reload got=%h exp=%h", dut_state(), m);
        end
    endtask

    task automatic test_flush_hz();
        logic [15:0] c0;
        rand_id(); plain_ctrl();
        bus.ID_Load_Inst = 1'b1; bus.ID_Rd = 4'd5;
        clock_edge();
        rand_id(); bus.ID_Rn = 4'd5; bus.ID_use_Rn = 1'b1; bus.flush = 1'b1;
        c0 = m.cnt;
        clock_edge();
        n_vec++;
        if ({bus.EX_valid, bus.bubble_cnt} !== {1'b0, c0 + 16'd1}) begin
            n_err++; $display("FAIL flush_hz got v=%b cnt=%0d exp v=0 cnt=%0d",
                              bus.EX_valid, bus.bubble_cnt, c0 + 16'd1);
        end
        bus.flush = 1'b0;
        clock_edge();
        n_vec++;
        if ({bus.EX_valid, bus.bubble_cnt} !== {1'b1, c0 + 16'd1}) begin
            n_err++; $display("FAIL flush_single got v=%b cnt=%0d exp v=1 cnt=%0d",
                              bus.EX_valid, bus.bubble_cnt, c0 + 16'd1);
        end
        rand_id(); bus.ID_Load_Inst = 1'b0; bus.ID_m_enable = 1'b1; bus.cond_pass = 1'b0;
        clock_edge();
        n_vec++;
        if ({bus.EX_valid, bus.EX_m_enable, bus.bubble_cnt} !== {1'b0, 1'b0, c0 + 16'd2}) begin
            n_err++; $display("FAIL condfail got v=%b men=%b cnt=%0d exp v=0 men=0 cnt=%0d",
                              bus.EX_valid, bus.EX_m_enable, bus.bubble_cnt, c0 + 16'd2);
        end
        n_vec++;
        if (dut_state() !== m) begin
            n_err++; $display("FAIL condfail_fields got=%h exp=%h", dut_state(), m);
        end
    endtask

    task automatic test_hold();
        ex_t snap;
        rand_id(); plain_ctrl();
        bus.ID_Load_Inst = 1'b1; bus.ID_Rd = 4'd7;
        clock_edge();
        snap = m;
        for (int i = 0; i < 3; i++) begin
            rand_id(); bus.hold = 1'b1; bus.flush = 1'(i == 1);
            bus.ID_Rn = 4'd7; bus.ID_use_Rn = 1'b1;
            #1;
            n_vec++;
            if (bus.stall_IF_ID !== 1'b1) begin
                n_err++; $display("FAIL hold_stall[%0d] got=%b exp=1", i, bus.stall_IF_ID);
            end
            clock_edge();
            n_vec++;
            if (dut_state() !== snap) begin
                n_err++; $display("FAIL hold_frozen[%0d] got=%h exp=%h", i, dut_state(), snap);
            end
        end
        plain_ctrl();
    endtask

    task automatic test_rd_only();
        rand_id(); plain_ctrl();
        bus.ID_Load_Inst = 1'b1; bus.ID_Rd = 4'd9;
        clock_edge();
        rand_id(); bus.ID_Rd = 4'd9; bus.ID_Rn = 4'd1; bus.ID_Rm = 4'd2;
        bus.ID_use_Rn = 1'b1; bus.ID_use_Rm = 1'b1;
        #1;
        n_vec++;
        if (bus.stall_IF_ID !== 1'b0) begin
            n_err++; $display("FAIL rd_only_stall got=%b exp=0", bus.stall_IF_ID);
        end
        clock_edge();
        n_vec++;
        if (bus.EX_valid !== 1'b1 || dut_state() !== m) begin
            n_err++; $display("FAIL rd_only_load got=%h exp=%h", dut_state(), m);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_id();
            bus.hold = 1'($urandom_range(0, 7) == 0);
            bus.flush = 1'($urandom_range(0, 7) == 0);
            bus.cond_pass = 1'($urandom_range(0, 7) != 0);
            #1;
            n_vec++;
            if (bus.stall_IF_ID !== model_stall()) begin
                n_err++; $display("FAIL rand_stall[%0d] got=%b exp=%b", i, bus.stall_IF_ID, model_stall());
            end
            clock_edge();
            n_vec++;
            if (dut_state() !== m) begin
                n_err++; $display("FAIL rand_state[%0d] got=%h exp=%h", i, dut_state(), m);
            end
        end
        plain_ctrl();
    endtask

    task automatic test_async_reset();
        rand_id(); plain_ctrl(); bus.ID_Load_Inst = 1'b0;
        clock_edge();
        #2 reset_n = 1'b0;
        #1;
        m = '0;
        n_vec++;
        if (dut_state() !== m || bus.stall_IF_ID !== 1'b0) begin
            n_err++; $display("FAIL async_reset got=%h stall=%b exp=%h stall=0",
                              dut_state(), bus.stall_IF_ID, m);
        end
        @(negedge clk);
        reset_n = 1'b1;
        // Pending hazard under hold is wiped by a mid-cycle reset.
        rand_id(); bus.ID_Load_Inst = 1'b1; bus.ID_Rd = 4'd2;
        clock_edge();
        bus.hold = 1'b1; bus.ID_Rn = 4'd2; bus.ID_use_Rn = 1'b1;
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        m = '0;
        plain_ctrl();
        #1;
        n_vec++;
        if (bus.stall_IF_ID !== 1'b0) begin
            n_err++; $display("FAIL reset_hz_stall got=%b exp=0", bus.stall_IF_ID);
        end
        clock_edge();
        n_vec++;
        if (bus.EX_valid !== 1'b1 || dut_state() !== m) begin
            n_err++; $display("FAIL reset_first_edge got=%h exp=%h", dut_state(), m);
        end
    endtask

    task automatic test_saturation();
        rand_id(); plain_ctrl(); bus.flush = 1'b1;
        for (int i = 0; i < 70000 && m.cnt != 16'hFFFE; i++) clock_edge();
        n_vec++;
        if (bus.bubble_cnt !== 16'hFFFE) begin
            n_err++; $display("FAIL sat_preload got=%h exp=fffe", bus.bubble_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            rand_id();
            clock_edge();
            n_vec++;
            if (bus.bubble_cnt !== 16'hFFFF || dut_state() !== m) begin
                n_err++; $display("FAIL sat_bubble[%0d] got=%h exp=%h", i, dut_state(), m);
            end
        end
        plain_ctrl(); rand_id();
        clock_edge();
        n_vec++;
        if (bus.bubble_cnt !== 16'hFFFF) begin
            n_err++; $display("FAIL sat_load got=%h exp=ffff", bus.bubble_cnt);
        end
    endtask

    initial begin
        m = '0;
        reset_n = 1'b0;
        plain_ctrl();
        rand_id();
        test_reset();
        test_basic();
        test_load_use();
        test_flush_hz();
        test_hold();
        test_rd_only();
        test_random();
        test_async_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
